codificador_dias: RTL
=====================

CODIFICADOR_DIAS -- requirements
Module: codificador_dias

Interface
REQ-001 Parameter: DIA_MAX, default 31, highest legal day of month accepted.
REQ-002 Port: Clock  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: Start  input  1  request to encode Dato_in; sampled only in IDLE.
REQ-005 Port: Formato  input  1  0: Ref = day-1 (0..30); 1: Ref = day (1..31); sampled with Start.
REQ-006 Port: Dato_in  input  8  packed BCD day, [7:4] tens, [3:0] units, as read from the RTC.
REQ-007 Port: Ref  output  5  binary day reference, the inverse of the day decoder's Ref input.
REQ-008 Port: Done  output  1  one-cycle pulse marking a completed request, valid or not.
REQ-009 Port: Error  output  1  qualifies Done; 1 = Dato_in rejected.
REQ-010 Port: Busy  output  1  high whenever state is not IDLE.

Function
REQ-011 FSM states SHALL be IDLE, CHECK, CONVERT, DONE.
REQ-012 IDLE with Start=1 at an edge SHALL capture Dato_in and Formato into internal registers and enter CHECK.
REQ-013 CHECK SHALL reject when units > 9, tens > 3, value = 0, or value > DIA_MAX; on reject, go to DONE with Error=1.
REQ-014 CHECK on accept SHALL load accumulator = units and tens counter T = tens; go to CONVERT if T>0, else DONE.
REQ-015 CONVERT SHALL add 10 to the accumulator and decrement T once per cycle; exit to DONE on the edge where T reaches 0.
REQ-016 Accumulator SHALL be 6 bits wide; no overflow is possible, since the maximum is 39 before the range check.
REQ-017 On entry to DONE with accept, Ref SHALL load accumulator-1 (Formato=0) or accumulator (Formato=1), truncated to 5 bits.
REQ-018 On reject, Ref SHALL hold its previous value.
REQ-019 Done SHALL be high for exactly the single cycle spent in DONE; Error is meaningful only while Done=1 and is 0 otherwise.
REQ-020 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-021 Latency: with Start sampled at edge 0, Done is high in the cycle after edge 1+T (T = tens digit); rejects finish after edge 1.
REQ-022 Start while Busy=1 SHALL be ignored, with no queuing.
REQ-023 Start is not accepted in the DONE cycle itself; the earliest new request is sampled on the edge after DONE.
REQ-024 Dato_in and Formato changes after capture SHALL NOT affect the result in flight.

Reset
REQ-025 Reset=1 SHALL force state IDLE, Ref=0, Done=0, Error=0, Busy=0, and clear accumulator and T, independent of Clock.
REQ-026 Reset asserted mid-operation SHALL abort the request with no Done pulse.
REQ-027 Reset wins over a simultaneous Start.
REQ-028 After Reset deasserts, the first Start SHALL be honored on the next rising edge.

Structure
REQ-029 A shared package SHALL hold the state encoding, BCD digit limits (9, 3), and the default DIA_MAX, for reuse by the day decoder and the future month/year coders.
REQ-030 BCD range checking SHALL live in one combinational sub-module, validador_bcd (inputs: byte, max; output: ok), reusable by the other date coders.

Verification
REQ-031 Dato_in=0x15, Formato=0, Start at edge 0 -> Done=1, Error=0, Ref=14 in the cycle after edge 2.
REQ-032 Dato_in=0x31, Formato=1 -> Ref=31 after edge 4; repeat with Formato=0 -> Ref=30; then 0x01, Formato=0 -> Ref=0 after edge 1.
REQ-033 Dato_in=0x1A, then 0x00, then 0x32 -> each gives Done=1, Error=1 after edge 1, with Ref unchanged from the prior valid result.
REQ-034 Start=1 held continuously with Dato_in changing during Busy -> only the first captured value is converted; the next Start is accepted on the edge after DONE.
REQ-035 Start with 0x29, then Reset pulsed during CONVERT -> outputs zero immediately, no Done pulse; next Start with 0x07, Formato=0 gives Ref=6.
REQ-036 Sweep 0x01..0x31, Formato=0 -> Ref 0..30 and round-trips through the day decoder to the original BCD value.

Source files
------------

// File: rtl/codificador_dias_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codificador_dias_pkg
// Description : State encoding, BCD digit limits and day bound shared by the
//               date coders.
// Revision    : 1.0 - initial release
// ============================================================================
package codificador_dias_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [3:0] c_BCD_UNITS_MAX   = 4'd9;
  localparam logic [3:0] c_BCD_TENS_MAX    = 4'd3;
  localparam int         c_DIA_MAX_DEFAULT = 31;

  // Binary value of a packed BCD byte; tens up to 15 still fits in 8 bits.
  function automatic logic [7:0] bcd_to_bin(input logic [7:0] bcd);
    logic [7:0] tens;
    logic [7:0] units;
    tens  = {4'd0, bcd[7:4]};
    units = {4'd0, bcd[3:0]};
    return 8'((tens << 3) + (tens << 1) + units);
  endfunction

endpackage
`default_nettype wire

// File: rtl/validador_bcd.sv
`default_nettype none
// ============================================================================
// Module      : validador_bcd
// Description : Combinational range check of a packed BCD byte against a max.
// Revision    : 1.0 - initial release
// ============================================================================
module validador_bcd
  import codificador_dias_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic [7:0] i_max,
  output logic       o_ok
);

  logic [3:0] units;
  logic [3:0] tens;
  logic [7:0] value;

  always_comb begin
    units = i_byte[3:0];
    tens  = i_byte[7:4];
    value = bcd_to_bin(i_byte);
    o_ok  = (units <= c_BCD_UNITS_MAX) &&
            (tens  <= c_BCD_TENS_MAX)  &&
            (value != 8'd0)            &&
            (value <= i_max);
  end

endmodule
`default_nettype wire

// File: rtl/codificador_dias.sv
`default_nettype none
// ============================================================================
// Module      : codificador_dias
// Description : Sequential BCD day-of-month to binary Ref encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module codificador_dias
  import codificador_dias_pkg::*;
#(
  parameter int DIA_MAX = c_DIA_MAX_DEFAULT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Formato,
  input  logic [7:0] Dato_in,
  output logic [4:0] Ref,
  output logic       Done,
  output logic       Error,
  output logic       Busy
);

  localparam logic [7:0] c_DIA_MAX = 8'(DIA_MAX);

  state_t     state_q, state_d;
  logic [7:0] dato_q, dato_d;
  logic       formato_q, formato_d;
  logic [5:0] acc_q, acc_d;
  logic [1:0] t_q, t_d;
  logic [4:0] ref_q, ref_d;
  logic       err_q, err_d;

  logic       val_ok;
  logic       accept_done;
  logic [5:0] acc_dec;

  validador_bcd u_validador (
    .i_byte (dato_q),
    .i_max  (c_DIA_MAX),
    .o_ok   (val_ok)
  );

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!val_ok || (dato_q[7:4] == 4'd0)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (t_q == 2'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: capture, accumulate tens, load Ref on accepted exit.
  always_comb begin
    dato_d    = dato_q;
    formato_d = formato_q;
    acc_d     = acc_q;
    t_d       = t_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          dato_d    = Dato_in;
          formato_d = Formato;
          err_d     = 1'b0;
        end
      end
      ST_CHECK: begin
        if (val_ok) begin
          acc_d = {2'b00, dato_q[3:0]};
          t_d   = dato_q[5:4];
          err_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_CONVERT: begin
        acc_d = acc_q + 6'd10;
        t_d   = t_q - 2'd1;
      end
      default: begin
      end
    endcase

    accept_done = (state_d == ST_DONE) &&
                  ((state_q == ST_CONVERT) || ((state_q == ST_CHECK) && val_ok));
    acc_dec     = acc_d - 6'd1;
    ref_d       = ref_q;
    if (accept_done) begin
      ref_d = formato_q ? acc_d[4:0] : acc_dec[4:0];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      dato_q    <= 8'd0;
      formato_q <= 1'b0;
      acc_q     <= 6'd0;
      t_q       <= 2'd0;
      ref_q     <= 5'd0;
      err_q     <= 1'b0;
    end else begin
      dato_q    <= dato_d;
      formato_q <= formato_d;
      acc_q     <= acc_d;
      t_q       <= t_d;
      ref_q     <= ref_d;
      err_q     <= err_d;
    end
  end

  // Output logic
  always_comb begin
    Ref   = ref_q;
    Done  = (state_q == ST_DONE);
    Error = (state_q == ST_DONE) && err_q;
    Busy  = (state_q != ST_IDLE);
  end

endmodule
`default_nettype wire
